ff_pipe_arbiter: RTL

//   Shares one DEPTH-stage registered bit pipeline (IO-isolated flip-flop chain) among NREQ requesters.

---
 rtl/ff_pipe_pkg.sv | 24 ++
 rtl/ff_pipe_rr_pick.sv | 37 +++
 rtl/ff_pipe_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ff_pipe_pkg.sv
// Shared types and helpers for the ff_pipe_arbiter slice.
// Combinational helpers only; no latency.
// No flow control.
package ff_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_BIT   = 1'b0;

    function automatic int owner_w(input int nreq);
        return (nreq > 2) ? $clog2(nreq) : 1;
    endfunction

    // Wraps at nreq so the pointer never reaches nreq for non-power-of-2 counts.
    function automatic int next_idx(input int idx, input int nreq);
        return (idx >= nreq - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ff_pipe_rr_pick.sv
// Rotate-priority picker: first asserted request at or after i_ptr, wrapping at NREQ.
// Purely combinational, zero latency.
// No backpressure; the caller gates the grant.
module ff_pipe_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0] w_sum;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(NREQ)) begin
                w_sum = w_sum - SW'(NREQ);
            end
            if (!o_vld && i_req[w_sum[IDX_W-1:0]]) begin
                o_vld                     = 1'b1;
                o_idx                     = w_sum[IDX_W-1:0];
                o_gnt[w_sum[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ff_pipe_arbiter.sv
// Round-robin share of a DEPTH-stage bit pipeline; FFPA_BURST_LOCK_EN adds burst locking.
// Latency: a bit presented with its grant in cycle c is at q in cycle c+DEPTH (advancing cycles).
// Backpressure: en=0 stalls every stage and withholds grants; drain_req/flush also withhold grants.
module ff_pipe_arbiter
    import ff_pipe_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DEPTH     = 5,
    parameter int BURST_LEN = 4,
    localparam int OWNER_W  = owner_w(NREQ)
) (
    input  logic               clk,
    input  logic               async_reset_n,
    input  logic               en,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    din,
    output logic [NREQ-1:0]    gnt,
    input  logic               drain_req,
    input  logic               flush,
    output logic               q,
    output logic               q_valid,
    output logic [OWNER_W-1:0] q_owner,
    output logic               busy,
    output logic               drained
);

    logic [DEPTH-1:0]               r_vld;
    logic [DEPTH-1:0]               r_dat;
    logic [DEPTH-1:0][OWNER_W-1:0]  r_own;
    state_t                         r_state;
    logic [OWNER_W-1:0]             r_ptr;

    logic [NREQ-1:0]    w_pick_gnt;
    logic [OWNER_W-1:0] w_pick_idx;
    logic               w_pick_vld;
    logic               w_allow;
    logic               w_acc;
    logic               w_busy;
    logic               w_dat_in;
    logic [OWNER_W-1:0] w_own_in;

    ff_pipe_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (OWNER_W)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    // Reset is folded in so gnt drops the instant reset asserts.
    assign w_allow  = async_reset_n && en && !flush && !drain_req && (r_state != DRAIN);
    assign gnt      = w_allow ? w_pick_gnt : '0;
    assign w_acc    = w_allow && w_pick_vld;
    assign w_dat_in = w_acc & din[w_pick_idx];
    assign w_own_in = w_acc ? w_pick_idx : '0;

    assign w_busy   = |r_vld;
    assign busy     = w_busy;
    assign q        = r_dat[DEPTH-1];
    assign q_valid  = r_vld[DEPTH-1];
    assign q_owner  = r_own[DEPTH-1];
    assign drained  = (r_state == DRAIN) && en && !flush && !w_busy;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_vld <= '0;
            r_dat <= '0;
            r_own <= '0;
        end else if (flush) begin
            r_vld <= '0;
        end else if (en) begin
            r_vld <= {r_vld[DEPTH-2:0], w_acc};
            r_dat <= {r_dat[DEPTH-2:0], w_dat_in};
            r_own <= {r_own[DEPTH-2:0], w_own_in};
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_state <= RST_STATE;
        end else if (flush) begin
            r_state <= IDLE;
        end else if (en) begin
            case (r_state)
                IDLE: begin
                    if (drain_req)  r_state <= DRAIN;
                    else if (w_acc) r_state <= RUN;
                end
                RUN: begin
                    if (drain_req)              r_state <= DRAIN;
                    else if (!w_busy && !w_acc) r_state <= IDLE;
                end
                DRAIN: begin
                    if (!w_busy) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FFPA_BURST_LOCK_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // A grant away from the locked owner means that owner dropped its request: start a fresh burst.
    assign w_cnt_nxt = (w_pick_idx == r_ptr) ? r_cnt + CNT_W'(1) : CNT_W'(1);

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_acc) begin
                if (int'(w_cnt_nxt) >= BURST_LEN) begin
                    r_ptr <= OWNER_W'(next_idx(int'(w_pick_idx), NREQ));
                    r_cnt <= '0;
                end else begin
                    r_ptr <= w_pick_idx;
                    r_cnt <= w_cnt_nxt;
                end
            end else if ((r_cnt != '0) && !req[r_ptr]) begin
                r_ptr <= OWNER_W'(next_idx(int'(r_ptr), NREQ));
                r_cnt <= '0;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_ptr <= '0;
        end else if (w_acc) begin
            r_ptr <= OWNER_W'(next_idx(int'(w_pick_idx), NREQ));
        end
    end
`endif

endmodule
